// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter granting one execution unit per cycle onto the CDB.
// Define CDB_ARBITER_OUT_REG_EN to register the cdb_* outputs (one-cycle latency).
module cdb_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int TAG_W = 4,
  parameter int ROB_PTR_W = 4,
  localparam int SRC_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_PORTS-1:0]          exu_req,
  output logic [NUM_PORTS-1:0]          exu_rdy,
  input  logic [NUM_PORTS*TAG_W-1:0]    exu_tag,
  input  logic [NUM_PORTS*ROB_PTR_W-1:0] exu_inst_id,
  input  logic [NUM_PORTS*32-1:0]       exu_wdata,
  output logic                          cdb_valid,
  output logic [TAG_W-1:0]              cdb_tag,
  output logic [ROB_PTR_W-1:0]          cdb_inst_id,
  output logic [31:0]                   cdb_wdata,
  output logic [SRC_W-1:0]              cdb_src
);

  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     nxt_ptr;
  logic [SRC_W-1:0]     gnt_idx;
  logic [SRC_W-1:0]     cand;
  logic [SRC_W:0]       sum;
  logic                 gnt_found;
  logic                 grant_ok;
  logic [TAG_W-1:0]     sel_tag;
  logic [ROB_PTR_W-1:0] sel_id;
  logic [31:0]          sel_data;

  // Search upward from rr_ptr, wrapping at NUM_PORTS
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(NUM_PORTS))
        sum = sum - (SRC_W+1)'(NUM_PORTS);
      cand = sum[SRC_W-1:0];
      if (!gnt_found && exu_req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant_ok = gnt_found & ~flush & ~rst;

  assign nxt_ptr = (gnt_idx == SRC_W'(NUM_PORTS-1)) ?
                   '0 : gnt_idx + 1'b1;

  always_comb begin
    exu_rdy = '0;
    if (grant_ok)
      exu_rdy[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (grant_ok)
      rr_ptr <= nxt_ptr;
  end

  always_comb begin
    sel_tag  = '0;
    sel_id   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_idx == SRC_W'(i)) begin
        sel_tag  = exu_tag[i*TAG_W +: TAG_W];
        sel_id   = exu_inst_id[i*ROB_PTR_W +: ROB_PTR_W];
        sel_data = exu_wdata[i*32 +: 32];
      end
    end
  end

`ifdef CDB_ARBITER_OUT_REG_EN
  logic valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      cdb_tag     <= '0;
      cdb_inst_id <= '0;
      cdb_wdata   <= '0;
      cdb_src     <= '0;
    end else begin
      valid_q <= grant_ok;
      if (grant_ok) begin
        cdb_tag     <= sel_tag;
        cdb_inst_id <= sel_id;
        cdb_wdata   <= sel_data;
        cdb_src     <= gnt_idx;
      end
    end
  end

  // A flush or reset in the broadcast cycle kills the stored result
  assign cdb_valid = valid_q & ~flush & ~rst;
`else
  assign cdb_valid   = grant_ok;
  assign cdb_tag     = sel_tag;
  assign cdb_inst_id = sel_id;
  assign cdb_wdata   = sel_data;
  assign cdb_src     = gnt_idx;
`endif

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, the number of execution-unit requesters, with the LSU on any one of them.
REQ-002 SHALL have parameter TAG_W, default 4, the physical destination tag width.
REQ-003 SHALL have parameter ROB_PTR_W, default 4, the ROB instruction-id width.
REQ-004 SHALL have port clk, input, 1 bit, the clock.
REQ-005 SHALL have port rst, input, 1 bit; the reset is rst, synchronous, active-high, and the clock is clk.
REQ-006 SHALL have port flush, input, 1 bit, a pipeline flush that suppresses all grants.
REQ-007 SHALL have port exu_req, input, NUM_PORTS bits, the per-port broadcast request.
REQ-008 SHALL have port exu_rdy, output, NUM_PORTS bits, the per-port grant/accept.
REQ-009 SHALL have port exu_tag, input, NUM_PORTS*TAG_W bits; port i occupies slice [i*TAG_W +: TAG_W].
REQ-010 SHALL have port exu_inst_id, input, NUM_PORTS*ROB_PTR_W bits, sliced per port in the same way.
REQ-011 SHALL have port exu_wdata, input, NUM_PORTS*32 bits, the per-port result data.
REQ-012 SHALL have port cdb_valid, output, 1 bit, a broadcast-valid strobe.
REQ-013 SHALL have port cdb_tag, output, TAG_W bits, the broadcast tag.
REQ-014 SHALL have port cdb_inst_id, output, ROB_PTR_W bits, the broadcast ROB id.
REQ-015 SHALL have port cdb_wdata, output, 32 bits, the broadcast result.
REQ-016 SHALL have port cdb_src, output, $clog2(NUM_PORTS) bits, the index of the granted port.

Function
REQ-017 SHALL grant at most one port per cycle; exu_rdy SHALL be one-hot or zero.
REQ-018 SHALL assert exu_rdy[i] only when exu_req[i]=1; a transfer occurs in a cycle with req&&rdy on a port.
REQ-019 SHALL derive exu_rdy combinationally from exu_req, the round-robin pointer and flush, with no dependence on cdb outputs.
REQ-020 Requesters SHALL hold req, tag, inst_id and wdata stable until granted; the arbiter SHALL NOT buffer ungranted requests.
REQ-021 Round-robin: SHALL search from port rr_ptr upward modulo NUM_PORTS and grant the first requesting port.
REQ-022 SHALL load rr_ptr with (granted index + 1) mod NUM_PORTS on a grant, and hold rr_ptr otherwise; wrap NUM_PORTS-1 -> 0.
REQ-023 Any continuously requesting port SHALL be granted within NUM_PORTS cycles, with no starvation.
REQ-024 flush=1 SHALL force exu_rdy=0 and leave rr_ptr unchanged.
REQ-025 flush=1 SHALL also deassert cdb_valid in the same cycle in either configuration.
REQ-026 cdb_tag/cdb_inst_id/cdb_wdata/cdb_src SHALL equal the granted port's payload/index whenever cdb_valid=1; they are don't-care otherwise.
REQ-027 With no requests, cdb_valid SHALL be 0 and rr_ptr SHALL be held.
REQ-028 Back-to-back grants SHALL be sustained at one broadcast per cycle.

Reset
REQ-029 During rst: rr_ptr=0, cdb_valid=0, cdb_tag/cdb_inst_id/cdb_wdata/cdb_src=0 (registered mode), exu_rdy=0.
REQ-030 rst asserted mid-broadcast SHALL drop the pending registered broadcast; the first cycle after reset SHALL grant from port 0.

Configuration
REQ-031 Macro CDB_ARBITER_OUT_REG_EN defined: cdb_* outputs SHALL be registered from the grant cycle, one-cycle latency; cdb_valid(t+1)=|exu_rdy(t); flush at t+1 SHALL clear cdb_valid combinationally at its output.
REQ-032 Macro CDB_ARBITER_OUT_REG_EN undefined: cdb_* outputs SHALL be combinational from the grant in the same cycle, zero latency; cdb_valid=|exu_rdy.

Verification
REQ-033 Reset, then exu_req=4'b0000 for 5 cycles -> cdb_valid=0 throughout; exu_rdy=0.
REQ-034 exu_req=4'b1111 held 8 cycles -> grants in order 0,1,2,3,0,1,2,3, one per cycle; cdb_src follows the grant order, delayed 1 cycle in registered mode.
REQ-035 rr_ptr=2 with exu_req=4'b0011 -> port 0 granted, then port 1; port 1 tag=4'hA, inst_id=4'h5, wdata=32'hDEADBEEF appears on cdb exactly once.
REQ-036 exu_req=4'b1000 with flush=1 for 2 cycles, then flush=0 -> no grant while flush=1; port 3 granted in the first cycle after; rr_ptr then equals 0.
REQ-037 exu_req=4'b0100 held 3 cycles with the requester dropping req after its grant -> exactly one broadcast of port 2's payload, with no duplicates.
REQ-038 rst asserted in the cycle after a grant (registered mode) -> cdb_valid=0 the next cycle; a subsequent exu_req=4'b1111 grants port 0 first.
